mask_centroid: RTL and testbench

//  Reads the 1-bit threshold mask displayed by the video mux and computes its per-frame centroid.

---
 rtl/video_pkg.sv | 21 ++
 rtl/seq_divider.sv | 81 ++++++++
 rtl/mask_centroid.sv | 186 ++++++++++++++++++
 tb/tb_mask_centroid.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video timing constants, coordinate types and the centroid FSM encoding.
// Sum and count widths are sized so a full 1280x720 mask cannot overflow.
package video_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int XW       = 11;
    localparam int YW       = 10;
    localparam int CW       = 21;
    localparam int SW       = 32;

    typedef logic [XW-1:0] hcount_t;
    typedef logic [YW-1:0] vcount_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } centroid_state_t;

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle, WIDTH iterations.
// The first iteration runs in the start cycle, so done_out pulses WIDTH cycles after start_in.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CNTW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNTW-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_src_rem;
    logic [WIDTH-1:0] w_src_quo;
    logic [WIDTH-1:0] w_src_div;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // The dividend shifts out of r_quo from the top while quotient bits enter at the bottom.
    always_comb begin
        w_src_rem = start_in ? '0 : r_rem;
        w_src_quo = start_in ? dividend_in : r_quo;
        w_src_div = start_in ? divisor_in : r_div;
        w_shifted = {w_src_rem, w_src_quo[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, w_src_div};
        if (w_trial[WIDTH]) begin
            w_rem_next = w_shifted[WIDTH-1:0];
            w_quo_next = {w_src_quo[WIDTH-2:0], 1'b0};
        end else begin
            w_rem_next = w_trial[WIDTH-1:0];
            w_quo_next = {w_src_quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_in) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_div  <= divisor_in;
                r_cnt  <= CNTW'(WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt - CNTW'(1);
                if (r_cnt == CNTW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient_out = r_quo;
    assign busy_out     = r_busy;
    assign done_out     = r_done;

endmodule

// File: rtl/mask_centroid.sv
// Per-frame centroid of the 1-bit threshold mask: accumulates x/y sums and a pixel count over
// active video, snapshots them on frame_done_in and divides with two sequential dividers.
module mask_centroid
    import video_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XW-1:0]   x_in,
    input  logic [YW-1:0]   y_in,
    input  logic            valid_in,
    input  logic            mask_in,
    input  logic            frame_done_in,
    output logic [XW-1:0]   x_out,
    output logic [YW-1:0]   y_out,
    output logic            found_out,
    output logic            valid_out,
    output logic            busy_out,
    output logic            overrun_out,
    output centroid_state_t state_out
);

    logic [SW-1:0]   r_sum_x;
    logic [SW-1:0]   r_sum_y;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_snap_x;
    logic [SW-1:0]   r_snap_y;
    logic [CW-1:0]   r_snap_count;
    logic            r_pend;
    centroid_state_t r_state;
    logic [XW-1:0]   r_x_out;
    logic [YW-1:0]   r_y_out;
    logic            r_found;
    logic            r_valid;
    logic            r_overrun;

    logic            w_pix;
    logic [SW-1:0]   w_close_x;
    logic [SW-1:0]   w_close_y;
    logic [CW-1:0]   w_close_count;
    logic            w_accept;
    centroid_state_t w_state_next;
    logic            w_start;
    logic            w_load;
    logic            w_empty;
    logic [SW-1:0]   w_quo_x;
    logic [SW-1:0]   w_quo_y;
    logic            w_done_x;
    logic            w_done_y;
    logic            w_busy_x;
    logic            w_busy_y;
    logic            w_unused_div;

    // Closing values include the pixel presented alongside frame_done_in.
    assign w_pix         = valid_in && mask_in;
    assign w_close_x     = r_sum_x + (w_pix ? {{(SW-XW){1'b0}}, x_in} : '0);
    assign w_close_y     = r_sum_y + (w_pix ? {{(SW-YW){1'b0}}, y_in} : '0);
    assign w_close_count = r_count + (w_pix ? CW'(1) : '0);
    assign w_accept      = frame_done_in && (r_state == IDLE) && !r_pend;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_count <= '0;
        end else if (frame_done_in) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_count <= '0;
        end else begin
            r_sum_x <= w_close_x;
            r_sum_y <= w_close_y;
            r_count <= w_close_count;
        end
    end

    // A frame end arriving while a result is still pending or in flight is dropped and flagged.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_snap_x     <= '0;
            r_snap_y     <= '0;
            r_snap_count <= '0;
            r_pend       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_snap_x     <= w_close_x;
                r_snap_y     <= w_close_y;
                r_snap_count <= w_close_count;
            end
            if (frame_done_in && !w_accept) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Divider handshake: start_in is a one-cycle request accepted unconditionally;
    // done_out is a one-cycle pulse with quotient_out valid in that same cycle.
    seq_divider #(.WIDTH(SW)) u_div_x (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (w_start),
        .dividend_in  (r_snap_x),
        .divisor_in   ({{(SW-CW){1'b0}}, r_snap_count}),
        .quotient_out (w_quo_x),
        .busy_out     (w_busy_x),
        .done_out     (w_done_x)
    );

    seq_divider #(.WIDTH(SW)) u_div_y (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (w_start),
        .dividend_in  (r_snap_y),
        .divisor_in   ({{(SW-CW){1'b0}}, r_snap_count}),
        .quotient_out (w_quo_y),
        .busy_out     (w_busy_y),
        .done_out     (w_done_y)
    );

    assign w_unused_div = ^{w_quo_x[SW-1:XW], w_quo_y[SW-1:YW], w_busy_x, w_busy_y};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_empty      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend) begin
                    if (r_snap_count != '0) begin
                        w_state_next = DIVIDE;
                        w_start      = 1'b1;
                    end else begin
                        w_state_next = DONE;
                        w_empty      = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (w_done_x && w_done_y) begin
                    w_state_next = DONE;
                    w_load       = 1'b1;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Coordinates hold across empty frames; only found_out reports the absence of mask pixels.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_x_out <= '0;
            r_y_out <= '0;
            r_found <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_state_next == DONE);
            if (w_load) begin
                r_x_out <= w_quo_x[XW-1:0];
                r_y_out <= w_quo_y[YW-1:0];
                r_found <= 1'b1;
            end else if (w_empty) begin
                r_found <= 1'b0;
            end
        end
    end

    assign x_out       = r_x_out;
    assign y_out       = r_y_out;
    assign found_out   = r_found;
    assign valid_out   = r_valid;
    assign busy_out    = (r_state == DIVIDE);
    assign overrun_out = r_overrun;
    assign state_out   = r_state;

endmodule

// File: tb/tb_mask_centroid.sv
// Directed bench for mask_centroid: a frame-level model predicts every result and its cycle,
// checked against the DUT every cycle, plus hand-computed centroids for each scenario.
module tb_mask_centroid;
    import video_pkg::*;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic [XW-1:0]   x_in = '0;
    logic [YW-1:0]   y_in = '0;
    logic            valid_in = 1'b0;
    logic            mask_in = 1'b0;
    logic            frame_done_in = 1'b0;
    logic [XW-1:0]   x_out;
    logic [YW-1:0]   y_out;
    logic            found_out;
    logic            valid_out;
    logic            busy_out;
    logic            overrun_out;
    centroid_state_t state_out;

    mask_centroid dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .x_in          (x_in),
        .y_in          (y_in),
        .valid_in      (valid_in),
        .mask_in       (mask_in),
        .frame_done_in (frame_done_in),
        .x_out         (x_out),
        .y_out         (y_out),
        .found_out     (found_out),
        .valid_out     (valid_out),
        .busy_out      (busy_out),
        .overrun_out   (overrun_out),
        .state_out     (state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int x;
        int y;
        bit found;
    } exp_t;

    exp_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    longint m_sx = 0;
    longint m_sy = 0;
    longint m_cnt = 0;
    int     m_busy_until = -1;
    int     m_busy_lo = -1;
    int     m_busy_hi = -2;
    int     hold_x = 0;
    int     hold_y = 0;
    bit     hold_found = 1'b0;
    bit     exp_overrun = 1'b0;
    bit     chk_en = 1'b0;
    int     last_valid_cyc = -1;
    int     n_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hold_x       = 0;
        hold_y       = 0;
        hold_found   = 1'b0;
        exp_overrun  = 1'b0;
        m_busy_until = -1;
        m_busy_lo    = -1;
        m_busy_hi    = -2;
        m_sx         = 0;
        m_sy         = 0;
        m_cnt        = 0;
    endtask

    // Frame-level model: a frame closing while a result is outstanding is an overrun.
    task automatic close_frame(input int t);
        if (t <= m_busy_until) begin
            exp_overrun = 1'b1;
        end else if (m_cnt != 0) begin
            exp_q.push_back('{t + SW + 2, int'(m_sx / m_cnt), int'(m_sy / m_cnt), 1'b1});
            m_busy_lo    = t + 2;
            m_busy_hi    = t + SW + 1;
            m_busy_until = t + SW + 2;
        end else begin
            exp_q.push_back('{t + 2, 0, 0, 1'b0});
            m_busy_until = t + 2;
        end
        m_sx  = 0;
        m_sy  = 0;
        m_cnt = 0;
    endtask

    task automatic compare_cycle();
        bit   exp_valid;
        exp_t e;
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        exp_valid = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
        check("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
        if (exp_valid) begin
            e = exp_q.pop_front();
            if (e.found) begin
                hold_x = e.x;
                hold_y = e.y;
            end
            hold_found = e.found;
        end
        if (valid_out === 1'b1) begin
            last_valid_cyc = cyc;
            n_valid++;
        end
        check("x_out", 32'(x_out), hold_x);
        check("y_out", 32'(y_out), hold_y);
        check("found_out", {31'd0, found_out}, {31'd0, hold_found});
        check("busy_out", {31'd0, busy_out}, {31'd0, (cyc >= m_busy_lo && cyc <= m_busy_hi)});
        check("overrun_out", {31'd0, overrun_out}, {31'd0, exp_overrun});
    endtask

    task automatic step(input int x, input int y, input bit v, input bit m, input bit fd,
                        input bit rst);
        int t;
        x_in          = XW'(x);
        y_in          = YW'(y);
        valid_in      = v;
        mask_in       = m;
        frame_done_in = fd;
        rst_in        = rst;
        t             = cyc;
        if (v && m) begin
            m_sx  += x;
            m_sy  += y;
            m_cnt += 1;
        end
        @(negedge clk_in);
        if (chk_en) compare_cycle();
        @(posedge clk_in);
        #1;
        cyc++;
        if (rst) model_reset();
        else if (fd) close_frame(t);
    endtask

    task automatic idle();
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_result(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no valid_out expected one by cycle %0d", name, cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        int t;
        int nv;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_reset();
        chk_en = 1'b1;

        check("reset x_out", 32'(x_out), 0);
        check("reset y_out", 32'(y_out), 0);
        check("reset found_out", {31'd0, found_out}, 0);
        check("reset valid_out", {31'd0, valid_out}, 0);
        check("reset busy_out", {31'd0, busy_out}, 0);
        check("reset overrun_out", {31'd0, overrun_out}, 0);

        // Single pixel
        idle();
        step(100, 50, 1'b1, 1'b1, 1'b0, 1'b0);
        t = cyc;
        step(1279, 719, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_result("single");
        check("single latency", last_valid_cyc, t + SW + 2);
        check("single x", 32'(x_out), 100);
        check("single y", 32'(y_out), 50);
        check("single found", {31'd0, found_out}, 1);

        // Empty frame: blanking mask pixels must not count
        step(5, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        step(6, 6, 1'b1, 1'b0, 1'b0, 1'b0);
        t = cyc;
        step(7, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_result("empty");
        check("empty latency", last_valid_cyc, t + 2);
        check("empty found", {31'd0, found_out}, 0);
        check("empty x held", 32'(x_out), 100);
        check("empty y held", 32'(y_out), 50);

        // Rectangle x 10..19, y 20..29
        for (int y = 20; y <= 29; y++) begin
            for (int x = 8; x <= 21; x++) step(x, y, 1'b1, (x >= 10 && x <= 19), 1'b0, 1'b0);
            step(1000, 700, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1279, 719, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_result("rect");
        check("rect x", 32'(x_out), 14);
        check("rect y", 32'(y_out), 24);
        check("rect found", {31'd0, found_out}, 1);

        // Top and bottom full rows with blanking mask in between; last pixel closes the frame
        for (int x = 0; x < H_ACTIVE; x++) step(x, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1279, 400, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int x = 0; x < H_ACTIVE - 1; x++) step(x, V_ACTIVE - 1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(H_ACTIVE - 1, V_ACTIVE - 1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_result("rows");
        check("rows x", 32'(x_out), 639);
        check("rows y", 32'(y_out), 359);

        // Overrun: second frame end 5 cycles after the first
        step(7, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        step(9, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        nv = n_valid;
        step(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle();
        step(500, 500, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_result("overrun");
        for (int i = 0; i < 40; i++) idle();
        check("overrun flag", {31'd0, overrun_out}, 1);
        check("overrun x", 32'(x_out), 8);
        check("overrun y", 32'(y_out), 4);
        check("overrun valid count", n_valid - nv, 1);

        // Reset during the tenth divider iteration
        step(40, 40, 1'b1, 1'b1, 1'b0, 1'b0);
        t = cyc;
        step(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        while (cyc < t + 10) idle();
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("abort x_out", 32'(x_out), 0);
        check("abort y_out", 32'(y_out), 0);
        check("abort found_out", {31'd0, found_out}, 0);
        check("abort busy_out", {31'd0, busy_out}, 0);
        check("abort overrun_out", {31'd0, overrun_out}, 0);
        check("abort valid_out", {31'd0, valid_out}, 0);
        for (int i = 0; i < 40; i++) idle();
        step(200, 300, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1279, 719, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_result("after reset");
        check("after reset x", 32'(x_out), 200);
        check("after reset y", 32'(y_out), 300);
        check("after reset found", {31'd0, found_out}, 1);
        for (int i = 0; i < 5; i++) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
